// File: rtl/vx_fpu_divsqrt_sched_pkg.sv
// Shared FPU types for the div/sqrt scheduler: exception flag record,
// scheduler state encoding and op codes.
`ifndef FFLAGS_BITS
`define FFLAGS_BITS 5
`endif

package vx_fpu_divsqrt_sched_pkg;

  localparam int FFLAGS_BITS = `FFLAGS_BITS;

  // IEEE exception flags in CSR fflags bit order {NV,DZ,OF,UF,NX}
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fpu_sched_state_t;

  localparam logic FPU_OP_DIV  = 1'b0;
  localparam logic FPU_OP_SQRT = 1'b1;

  // A clear drops previously accumulated bits but never the flags of the
  // op completing in the same cycle.
  function automatic fflags_t fflags_merge(fflags_t acc, fflags_t fresh, logic clr);
    return clr ? fresh : fflags_t'(acc | fresh);
  endfunction

endpackage

// File: rtl/vx_fpu_divsqrt_sched_rr_grant.sv
// Round-robin grant: one-hot of the first valid requester at or after ptr,
// searching upward and wrapping to 0, plus its index.
module vx_rr_grant #(
  parameter int NUM_REQS = 4,
  localparam int IDXW = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [IDXW-1:0]     ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDXW-1:0]     idx,
  output logic                any
);

  // Walk the requesters starting at ptr and take the first valid one.
  always_comb begin
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    any   = |valid;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/vx_fpu_divsqrt_sched.sv
// Scheduler sharing one iterative FP div/sqrt unit among NUM_REQS requesters.
// Round-robin grant, one op in flight, response steered back to the owner,
// sticky per-requester exception flags with CSR clear.
// Optional build macro FPU_SCHED_PERF_EN adds busy/stall performance counters.
//
// state | meaning
// IDLE  | arbitrating; req_ready carries the one-hot grant
// ISSUE | holding unit_req_valid with latched op/operands
// WAIT  | unit busy; waiting for the result pulse
// RESP  | presenting result to the owning requester
module vx_fpu_divsqrt_sched
  import vx_fpu_divsqrt_sched_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int TAG_WIDTH = 8,
  parameter int FLEN      = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  input  logic [NUM_REQS-1:0]                 req_op,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]       req_tag,
  input  logic [NUM_REQS*2*FLEN-1:0]          req_data,
  output logic [NUM_REQS-1:0]                 req_ready,
  output logic                                unit_req_valid,
  input  logic                                unit_req_ready,
  output logic                                unit_req_op,
  output logic [2*FLEN-1:0]                   unit_req_data,
  input  logic                                unit_rsp_valid,
  input  logic [FLEN-1:0]                     unit_rsp_result,
  input  logic [`FFLAGS_BITS-1:0]             unit_rsp_fflags,
  output logic [NUM_REQS-1:0]                 rsp_valid,
  input  logic [NUM_REQS-1:0]                 rsp_ready,
  output logic [TAG_WIDTH-1:0]                rsp_tag,
  output logic [FLEN-1:0]                     rsp_result,
  output logic [`FFLAGS_BITS-1:0]             rsp_fflags,
  output logic [NUM_REQS*`FFLAGS_BITS-1:0]    sticky_fflags,
  input  logic [NUM_REQS-1:0]                 fflags_clr
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [63:0]                         perf_busy_cycles,
  output logic [63:0]                         perf_stall_cycles
`endif
);

  localparam int IDXW = $clog2(NUM_REQS);

  fpu_sched_state_t state, state_next;

  logic [IDXW-1:0]      rr_ptr;
  logic [IDXW-1:0]      owner;
  logic                 op_q;
  logic [2*FLEN-1:0]    data_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [FLEN-1:0]      result_q;
  fflags_t              fflags_q;
  fflags_t              sticky [NUM_REQS];

  logic [NUM_REQS-1:0]  grant;
  logic [IDXW-1:0]      grant_idx;
  logic                 grant_any;
  logic                 accept;
  logic                 rsp_capture;

  vx_rr_grant #(.NUM_REQS(NUM_REQS)) u_rr_grant (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign accept      = (state == IDLE) && grant_any;
  assign rsp_capture = (state == WAIT) && unit_rsp_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; only IDLE exposes the grant.
  always_comb begin
    state_next     = state;
    req_ready      = '0;
    unit_req_valid = 1'b0;
    rsp_valid      = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_any) state_next = ISSUE;
      end
      ISSUE: begin
        unit_req_valid = 1'b1;
        if (unit_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (unit_rsp_valid) state_next = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted request and the unit result; advance the pointer past the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      owner    <= '0;
      op_q     <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      if (accept) begin
        owner  <= grant_idx;
        op_q   <= req_op[grant_idx];
        data_q <= req_data[int'(grant_idx)*2*FLEN +: 2*FLEN];
        tag_q  <= req_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
        rr_ptr <= (int'(grant_idx) == NUM_REQS-1) ? '0 : grant_idx + 1'b1;
      end
      if (rsp_capture) begin
        result_q <= unit_rsp_result;
        fflags_q <= unit_rsp_fflags;
      end
    end
  end

  // Sticky flag accumulation; clears apply in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) sticky[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        sticky[i] <= fflags_merge(sticky[i],
                                  (rsp_capture && owner == IDXW'(i)) ? fflags_t'(unit_rsp_fflags) : '0,
                                  fflags_clr[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_sticky
    assign sticky_fflags[g*`FFLAGS_BITS +: `FFLAGS_BITS] = sticky[g];
  end

  assign unit_req_op   = op_q;
  assign unit_req_data = data_q;
  assign rsp_tag       = tag_q;
  assign rsp_result    = result_q;
  assign rsp_fflags    = fflags_q;

`ifdef FPU_SCHED_PERF_EN
  // Busy = any non-IDLE cycle; stall = someone waiting while nobody is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state != IDLE) perf_busy_cycles <= perf_busy_cycles + 64'd1;
      if (|req_valid && !(|req_ready)) perf_stall_cycles <= perf_stall_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_fpu_divsqrt_sched.sv
// Self-checking bench for vx_fpu_divsqrt_sched: directed scenarios followed by
// randomized operations checked against a transaction-level reference model.
module tb_vx_fpu_divsqrt_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_op, req_ready;
  logic [31:0]  req_tag;
  logic [255:0] req_data;
  logic         unit_req_valid, unit_req_ready, unit_req_op;
  logic [63:0]  unit_req_data;
  logic         unit_rsp_valid;
  logic [31:0]  unit_rsp_result;
  logic [4:0]   unit_rsp_fflags;
  logic [3:0]   rsp_valid, rsp_ready;
  logic [7:0]   rsp_tag;
  logic [31:0]  rsp_result;
  logic [4:0]   rsp_fflags;
  logic [19:0]  sticky_fflags;
  logic [3:0]   fflags_clr;
`ifdef FPU_SCHED_PERF_EN
  logic [63:0]  perf_busy_cycles, perf_stall_cycles;
`endif

  vx_fpu_divsqrt_sched dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_tag         (req_tag),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .unit_req_valid  (unit_req_valid),
    .unit_req_ready  (unit_req_ready),
    .unit_req_op     (unit_req_op),
    .unit_req_data   (unit_req_data),
    .unit_rsp_valid  (unit_rsp_valid),
    .unit_rsp_result (unit_rsp_result),
    .unit_rsp_fflags (unit_rsp_fflags),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_tag         (rsp_tag),
    .rsp_result      (rsp_result),
    .rsp_fflags      (rsp_fflags),
    .sticky_fflags   (sticky_fflags),
    .fflags_clr      (fflags_clr)
`ifdef FPU_SCHED_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: round-robin pointer and sticky flags per requester
  int         ptr_m;
  logic [4:0] sticky_m [4];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic int exp_owner(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [19:0] sticky_vec();
    logic [19:0] s;
    for (int i = 0; i < 4; i++) s[i*5 +: 5] = sticky_m[i];
    return s;
  endfunction

  task automatic randomize_reqs();
    req_op = 4'($urandom);
    req_tag = $urandom;
    for (int i = 0; i < 8; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; unit_req_ready = 0; unit_rsp_valid = 0; unit_rsp_result = '0;
    unit_rsp_fflags = '0; rsp_ready = '0; fflags_clr = '0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) sticky_m[i] = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_unit_valid"}, unit_req_valid, 0);
    chk({tag, "_unit_op"}, unit_req_op, 0);
    chk({tag, "_unit_data"}, unit_req_data, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_tag"}, rsp_tag, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_fflags"}, rsp_fflags, 0);
    chk({tag, "_sticky"}, sticky_fflags, 0);
  endtask

  // One full operation: arbitration, issue (with optional unit stall and
  // stray result pulses), unit latency, response with optional backpressure.
  task automatic serve(input int lat, input int stall, input int hold,
                       input logic [4:0] ff, input logic [3:0] clr, output int owner);
    logic [7:0]  tag_e;
    logic [63:0] dat_e;
    logic        op_e;
    logic [31:0] res;
    logic [3:0]  oh;
    int          c0;
    #1;
    owner = exp_owner(req_valid, ptr_m);
    chk("grant", req_ready, (owner < 0) ? 4'b0 : (4'b1 << owner));
    if (owner < 0) return;
    oh    = 4'b1 << owner;
    tag_e = req_tag[owner*8 +: 8];
    dat_e = req_data[owner*64 +: 64];
    op_e  = req_op[owner];
    tick();
    c0 = cyc;
    req_tag[owner*8 +: 8] = 8'($urandom);
    req_data[owner*64 +: 32] = $urandom;
    req_op[owner] = 1'($urandom);
    #1;
    chk("issue_valid", unit_req_valid, 1);
    chk("issue_op", unit_req_op, op_e);
    chk("issue_data", unit_req_data, dat_e);
    chk("issue_ready_low", req_ready, 0);
    for (int s = 0; s < stall; s++) begin
      unit_rsp_valid = 1; unit_rsp_fflags = 5'h1f;
      tick();
      unit_rsp_valid = 0; unit_rsp_fflags = 0;
      #1;
      chk("issue_hold", {unit_req_valid, unit_req_op, unit_req_data}, {1'b1, op_e, dat_e});
    end
    unit_req_ready = 1;
    tick();
    unit_req_ready = 0;
    #1;
    chk("wait_unit_valid_low", unit_req_valid, 0);
    repeat (lat) tick();
    chk("wait_no_rsp", rsp_valid, 0);
    res = $urandom;
    unit_rsp_valid = 1; unit_rsp_result = res; unit_rsp_fflags = ff; fflags_clr = clr;
    tick();
    unit_rsp_valid = 0; unit_rsp_fflags = 0; fflags_clr = 0;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] fresh;
      fresh = (i == owner) ? ff : 5'b0;
      sticky_m[i] = clr[i] ? fresh : (sticky_m[i] | fresh);
    end
    #1;
    if (stall == 0) chk("latency", cyc - c0, lat + 2);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_tag", rsp_tag, tag_e);
    chk("rsp_result", rsp_result, res);
    chk("rsp_fflags", rsp_fflags, ff);
    chk("sticky", sticky_fflags, sticky_vec());
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh;
      tick();
      #1;
      chk("hold_rsp", {rsp_valid, rsp_tag, rsp_result, rsp_fflags}, {oh, tag_e, res, ff});
      chk("hold_idle", {req_ready, unit_req_valid}, 0);
    end
    rsp_ready = oh;
    tick();
    rsp_ready = 0;
    #1;
    chk("rsp_done", rsp_valid, 0);
    ptr_m = (owner + 1) % 4;
  endtask

  initial begin
    int own;
    reset = 1'b1;
    req_op = '0; req_tag = '0; req_data = '0;
    do_reset();
    chk_all_zero("reset");

    // single div from requester 0, unit latency 10
    req_valid = 4'b0001; req_op = 4'b0000; req_tag = 32'h0000_00a5;
    req_data[63:0] = 64'h4000_0000_3f80_0000;
    serve(10, 0, 0, 5'b00100, 4'b0000, own);
    chk("t1_owner", own, 0);

    // sticky clear colliding with a new flag for requester 1
    req_valid = 4'b0010;
    serve(3, 0, 0, 5'b10000, 4'b0000, own);
    chk("t4_prior", sticky_fflags[9:5], 5'b10000);
    serve(4, 1, 0, 5'b00001, 4'b0010, own);
    chk("t4_sticky1", sticky_fflags[9:5], 5'b00001);

    // response backpressure on requester 2
    req_valid = 4'b0100;
    serve(2, 0, 5, 5'b01000, 4'b0000, own);
    chk("t3_owner", own, 2);
    req_valid = 4'b0000;
    #1;
    chk("no_valid_no_grant", req_ready, 0);
    tick();
    chk("no_valid_no_issue", unit_req_valid, 0);

    // reset in the middle of WAIT, then a late result pulse
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    unit_req_ready = 1;
    tick();
    unit_req_ready = 0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk_all_zero("rst_edge");
    reset = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) sticky_m[i] = '0;
    unit_rsp_valid = 1; unit_rsp_fflags = 5'h1f; unit_rsp_result = 32'hdead_beef;
    tick();
    unit_rsp_valid = 0; unit_rsp_fflags = 0;
    #1;
    chk("late_rsp_valid", rsp_valid, 0);
    chk("late_rsp_sticky", sticky_fflags, 0);
    chk("late_rsp_result", rsp_result, 0);

    // all requesters valid: strict rotation from pointer 0
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve(1 + n, 0, 0, 5'(n + 1), 4'b0000, own);
      chk("rr_order", own, n % 4);
    end
    req_valid = 4'b0000;

`ifdef FPU_SCHED_PERF_EN
    begin
      int nb;
      do_reset();
      chk("perf_rst_busy", perf_busy_cycles, 0);
      chk("perf_rst_stall", perf_stall_cycles, 0);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0001;
      nb = 0;
      unit_req_ready = 1;
      tick(); nb++;
      unit_req_ready = 0;
      repeat (9) begin tick(); nb++; end
      unit_rsp_valid = 1;
      tick(); nb++;
      unit_rsp_valid = 0;
      rsp_ready = 4'b0010;
      tick(); nb++;
      rsp_ready = 0;
      chk("perf_nb", nb, 12);
      chk("perf_busy", perf_busy_cycles, nb);
      chk("perf_stall", perf_stall_cycles, nb);
      req_valid = 4'b0000;
      ptr_m = 2;
    end
`endif

    // randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      randomize_reqs();
      req_valid = 4'($urandom_range(1, 15));
      serve($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 3),
            5'($urandom), 4'($urandom), own);
    end
    req_valid = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
